// File: rtl/tbus_mem_responder_pkg.sv
// Shared tbus definitions and responder helpers.
// Supplies the tbus operation-type macros (guarded so that an existing
// definition elsewhere in the tree takes precedence) and the request
// latch type used by the memory responder.

`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'd0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'd1
`endif

package tbus_mem_responder_pkg;

   // Data path width of one memory word.
   localparam int TBUS_DATA_W = 64;

   // Width of the latency down-counter (LATENCY is limited to 1..15).
   localparam int TBUS_LAT_W = 4;

   typedef logic [TBUS_DATA_W-1:0] tbus_word_t;

   // Request fields captured on accept.
   typedef struct packed {
      logic       is_write;
      tbus_word_t data;
      tbus_word_t mask;
   } tbus_req_t;

   // Bitwise merge: bits with mask=1 take new data, others keep old data.
   function automatic tbus_word_t tbus_merge_masked(input tbus_word_t old_word,
                                                     input tbus_word_t new_word,
                                                     input tbus_word_t mask);
      return (old_word & ~mask) | (new_word & mask);
   endfunction

endpackage

// File: rtl/tbus_sram.sv
// Single-port synchronous RAM, DEPTH x 64, per-bit write mask and a
// registered read output. Contents are not reset.

module tbus_sram
   import tbus_mem_responder_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  tbus_word_t      wdata_i,
   input  tbus_word_t      wmask_i,
   output tbus_word_t      rdata_o
);

   tbus_word_t mem_q [DEPTH];
   tbus_word_t rdata_q;

   // Masked read-modify-write on write; registered read on read.
   always_ff @(posedge clock) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= tbus_merge_masked(mem_q[addr_i], wdata_i, wmask_i);
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tbus_mem_responder.sv
// tbus request/response responder backed by a local doubleword memory.
// One request in flight at a time; RAM is issued LATENCY cycles after the
// accept and a single-cycle done pulse follows one cycle later.
// Optional feature macro: TBUS_RESP_FLUSH_EN adds flush_valid, which aborts
// an in-flight read (writes always complete).
//
// Handshake: a request transfers on a rising edge where tbus_index_valid and
// tbus_index_ready are both high; the initiator holds valid and payload
// stable until then. ready depends only on state (and flush_valid), never on
// valid. Completion is a one-cycle tbus_operation_done pulse with
// tbus_read_data valid in that same cycle (zero for writes).

module tbus_mem_responder
   import tbus_mem_responder_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int LATENCY   = 2
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        tbus_index_valid,
   output logic                        tbus_index_ready,
   input  logic [63:0]                 tbus_index,
   input  logic [63:0]                 tbus_write_data,
   input  logic [63:0]                 tbus_write_mask,
   input  logic [`TBUS_OPTYPE_RANGE]   tbus_operation_type,
   output logic [63:0]                 tbus_read_data,
   output logic                        tbus_operation_done,
   output logic [1:0]                  debug_state_o
`ifdef TBUS_RESP_FLUSH_EN
   ,
   input  logic                        flush_valid
`endif
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                state_q;
   logic [TBUS_LAT_W-1:0] cnt_q;
   logic [AW-1:0]         addr_q;
   tbus_req_t             req_q;
   logic                  done_q;

   logic                  fire;
   logic                  flush_rd;
   logic                  ram_en;
   tbus_word_t            ram_rdata;

   // Address bits below the doubleword and above the memory size are dropped.
   logic                  unused_index_bits;
   assign unused_index_bits = ^{tbus_index[63:AW+3], tbus_index[2:0]};

`ifdef TBUS_RESP_FLUSH_EN
   assign tbus_index_ready = (state_q == ST_IDLE) & ~flush_valid;
   // Flush only aborts reads that are in flight.
   assign flush_rd = flush_valid & ~req_q.is_write & (state_q != ST_IDLE);
`else
   assign tbus_index_ready = (state_q == ST_IDLE);
   assign flush_rd = 1'b0;
`endif

   assign fire = tbus_index_valid & tbus_index_ready;

   // RAM is issued on the last BUSY cycle unless the read is being aborted.
   assign ram_en = (state_q == ST_BUSY) & (cnt_q == '0) & ~flush_rd;

   // Request FSM: accept, count down the latency, respond for one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         req_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (fire) begin
                  addr_q         <= tbus_index[AW+2:3];
                  req_q.is_write <= (tbus_operation_type == `TBUS_WRITE);
                  req_q.data     <= tbus_write_data;
                  req_q.mask     <= tbus_write_mask;
                  cnt_q          <= TBUS_LAT_W'(LATENCY - 1);
                  state_q        <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (flush_rd) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  state_q <= ST_RESP;
                  done_q  <= 1'b1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   tbus_sram #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_sram (
      .clock   (clock),
      .en_i    (ram_en),
      .we_i    (req_q.is_write),
      .addr_i  (addr_q),
      .wdata_i (req_q.data),
      .wmask_i (req_q.mask),
      .rdata_o (ram_rdata)
   );

   // A flush coinciding with the response cycle of a read wins over done.
   assign tbus_operation_done = done_q & ~flush_rd;
   assign tbus_read_data      = (done_q & ~flush_rd & ~req_q.is_write) ? ram_rdata : '0;
   assign debug_state_o       = state_q;

endmodule

// File: doc/tbus_mem_responder.md
# tbus_mem_responder

Responder end of the trinity bus (tbus) request/response channel: accepts one request at a time from an arbiter-side initiator such as the load unit or store path, performs a masked 64-bit read or write on a local doubleword memory after a fixed latency, and returns a single-cycle completion pulse with read data. It serves as the memory model behind the dcache arbiter in simulation and as a simple on-chip scratch memory. An optional flush input aborts an in-flight read.

## Interface
- MEM_DEPTH, 1024: number of 64-bit words; power of two.
- LATENCY, 2: cycles from the accept cycle to RAM issue; range 1–15.
- clock  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- tbus_index_valid  input  1  request valid; initiator holds it and its payload stable until ready.
- tbus_index_ready  output  1  responder can accept a request.
- tbus_index  input  64  byte address; bits [2:0] ignored.
- tbus_write_data  input  64  write data.
- tbus_write_mask  input  64  per-bit write enable.
- tbus_operation_type  input  `TBUS_OPTYPE_RANGE  `TBUS_WRITE selects a write; any other value selects a read.
- tbus_read_data  output  64  read data; valid only while done is high.
- tbus_operation_done  output  1  one-cycle completion pulse.
- flush_valid  input  1  abort an in-flight read; present only with TBUS_RESP_FLUSH_EN.

## Operation
- FSM states: IDLE, BUSY, RESP.
- tbus_index_ready = (state == IDLE) & ~flush_valid. Without the macro the ~flush_valid term is absent.
- Fire = valid & ready.
  - Latches index, write_data, write_mask and an is_write flag.
  - Loads the counter with LATENCY-1.
  - Moves to BUSY.
- BUSY with counter != 0: decrement the counter.
- BUSY with counter == 0: issue the RAM access and move to RESP.
  - Word index = index[$clog2(MEM_DEPTH)+2:3]. Higher address bits are ignored, so accesses wrap.
  - Write: mem[w] <= (mem[w] & ~mask) | (data & mask).
  - Read: synchronous; data is available next cycle.
- RESP: tbus_operation_done = 1; then return to IDLE.
  - Read: tbus_read_data = RAM output.
  - Write: tbus_read_data = 0.
- Only one request is outstanding at a time. No accept is possible in BUSY or RESP.
- Flush (macro enabled) of an in-flight read:
  - Condition: flush_valid is high while a read is in BUSY or RESP.
  - Done is suppressed that same cycle; flush wins over a coincident done.
  - State returns to IDLE next cycle.
- Writes ignore flush and always complete with done.
- Flush in IDLE has no effect, except that ready is low that cycle.
- Reset, including mid-operation:
  - State goes to IDLE and the counter and latches are cleared.
  - Reset values: ready = 1, done = 0, read_data = 0.
  - RAM contents are not reset.

## Timing
- Fire in cycle T: RAM issue at T+LATENCY, done at T+LATENCY+1.
- Ready returns at T+LATENCY+2, so back-to-back throughput is one request per LATENCY+2 cycles.
- ready is combinational from state and flush_valid only. There is no valid→ready path.
- Done and read_data come from the RESP state and the RAM output register; there is no combinational path from request inputs.
- A read following a write to the same word returns the written data.

## Configuration
- TBUS_RESP_FLUSH_EN defined:
  - The flush_valid port exists.
  - Reads are abortable as described; ready is gated by flush_valid.
- TBUS_RESP_FLUSH_EN undefined:
  - No flush_valid port.
  - Every accepted request produces exactly one done pulse.

## Structure
- The shared defines package supplies `TBUS_READ, `TBUS_WRITE and `TBUS_OPTYPE_RANGE. The responder uses these and does not redefine them.
- The FSM state encoding is local to the block.
- Sub-module tbus_sram: single-port synchronous RAM, MEM_DEPTH x 64, with a per-bit write mask and a registered read output.

## Test plan
- Write then read, LATENCY=2:
  - Write 0xDEADBEEF_CAFEF00D to index 0x40 with mask all-ones; fire at T → done at T+3, read_data 0.
  - Read index 0x40 → done three cycles after its fire, read_data 0xDEADBEEF_CAFEF00D.
- Partial mask:
  - Write 0x11 with mask 0xFF to index 0x40 → next read returns 0xDEADBEEF_CAFEF011.
- Backpressure and ignored low bits:
  - Hold valid through BUSY/RESP → ready is 0 until IDLE; exactly one done per fire.
  - Index 0x47 reads the same word as 0x40.
- Flush (macro enabled):
  - flush_valid in the RESP cycle of a read → done stays 0; ready is 1 the next cycle.
  - flush_valid during a write → done still pulses and memory is updated.
- Reset mid-BUSY:
  - Assert reset_n low → immediately ready = 1, done = 0.
  - Previously written word 0x40 still reads 0xDEADBEEF_CAFEF011.
- Wrap, MEM_DEPTH=1024:
  - Write index 0x2000 → a read of index 0x0 returns that data.
